// File: rtl/fir_tdm_arbiter_if.sv
// Sample request/capture and filtered-result bundle for the shared 3-tap FIR.
// The requester drives req/din and watches ack; the block drives everything else.
interface fir_tdm_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      ack;
    logic [DW-1:0]   dout;
    logic [1:0]      dout_ch;
    logic            dout_vld;
    logic            busy;

    modport master (
        output req, din,
        input  ack, dout, dout_ch, dout_vld, busy
    );

    modport slave (
        input  req, din,
        output ack, dout, dout_ch, dout_vld, busy
    );
endinterface

// File: rtl/fir_tdm_arbiter.sv
// Round-robin 4-channel time-shared 1-2-1 low-pass MAC; dout_vld 4 cycles after ack.
// No backpressure: requests wait in IDLE, one sample accepted per 5 cycles at most.
module fir_tdm_arbiter #(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fir_tdm_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, TAP0, TAP1, TAP2, OUT} state_t;

    state_t        state, state_nxt;
    logic [1:0]    ptr;
    logic [1:0]    g;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;
    logic          gnt_found;
    logic          grant;
    logic [DW-1:0] x0;
    logic [DW+1:0] acc;
    logic [DW-1:0] h1 [4];
    logic [DW-1:0] h2 [4];
    logic [3:0]    ack;
    logic [DW-1:0] dout;
    logic [1:0]    dout_ch;
    logic          dout_vld;

    // First requesting channel at or after ptr, wrapping 3 -> 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        cand      = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + k[1:0];
            if (!gnt_found && bus.req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant = (state == IDLE) && gnt_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = TAP0;
            TAP0:    state_nxt = TAP1;
            TAP1:    state_nxt = TAP2;
            TAP2:    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            g        <= '0;
            x0       <= '0;
            acc      <= '0;
            ack      <= '0;
            dout     <= '0;
            dout_ch  <= '0;
            dout_vld <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h1[i] <= '0;
                h2[i] <= '0;
            end
        end else begin
            ack      <= '0;
            dout_vld <= 1'b0;
            if (grant) begin
                x0  <= bus.din[DW*gnt_idx +: DW];
                g   <= gnt_idx;
                ptr <= gnt_idx + 2'd1;
                ack <= 4'b0001 << gnt_idx;
            end
            // Two guard bits in acc hold x0 + 2*h1 + h2 without overflow.
            case (state)
                TAP0: acc <= {2'b00, x0};
                TAP1: acc <= acc + {1'b0, h1[g], 1'b0};
                TAP2: acc <= acc + {2'b00, h2[g]};
                OUT: begin
                    dout     <= acc[DW+1:2];
                    dout_ch  <= g;
                    dout_vld <= 1'b1;
                    h2[g]    <= h1[g];
                    h1[g]    <= x0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack      = ack;
    assign bus.dout     = dout;
    assign bus.dout_ch  = dout_ch;
    assign bus.dout_vld = dout_vld;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_fir_tdm_arbiter.sv
// Bench for fir_tdm_arbiter: directed table, hand-built corner sequences and random
// request rounds checked against a transaction-level filter/arbitration model.
module tb_fir_tdm_arbiter;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    fir_tdm_arbiter_if #(.DW(DW)) bus();

    fir_tdm_arbiter #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] vec;
        int         ch;
        int         cyc;
    } ack_ev_t;

    typedef struct {
        int ch;
        int dout;
        int cyc;
    } out_ev_t;

    typedef struct {
        int ch;
        int x;
        int y;
    } vec_t;

    ack_ev_t ack_q[$];
    out_ev_t out_q[$];

    function automatic int first_bit(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Event recorder: every ack pulse and every result strobe, stamped with the cycle.
    always @(negedge clk) begin
        if (bus.ack != 4'b0000)
            ack_q.push_back('{bus.ack, first_bit(bus.ack), cyc});
        if (bus.dout_vld)
            out_q.push_back('{int'(bus.dout_ch), int'(bus.dout), cyc});
    end

    int n_vec = 0;
    int n_err = 0;
    int ack_base;
    int out_base;
    int exp_ch[$];
    int exp_y[$];

    // Reference model: per-channel sample history plus the last granted channel.
    int m_h1[4];
    int m_h2[4];
    int m_last;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_h1[i] = 0;
            m_h2[i] = 0;
        end
        m_last = 3;
    endfunction

    function automatic int model_next(logic [3:0] m);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (m[c]) begin
                m_last = c;
                return c;
            end
        end
        return -1;
    endfunction

    function automatic int model_filter(int c, int x);
        int y;
        y = (x + 2 * m_h1[c] + m_h2[c]) / 4;
        m_h2[c] = m_h1[c];
        m_h1[c] = x;
        return y;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_checks();
        chk("rst_ack",      int'(bus.ack),      0);
        chk("rst_dout",     int'(bus.dout),     0);
        chk("rst_dout_ch",  int'(bus.dout_ch),  0);
        chk("rst_dout_vld", int'(bus.dout_vld), 0);
        chk("rst_busy",     int'(bus.busy),     0);
    endtask

    task automatic do_reset(input logic [3:0] hold_mask);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        bus.din = '0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        bus.req = hold_mask;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_stream(input bit spacing);
        int n_a, n_o, n;
        n_a = ack_q.size() - ack_base;
        n_o = out_q.size() - out_base;
        chk("ack_count", n_a, exp_ch.size());
        chk("out_count", n_o, exp_ch.size());
        n = exp_ch.size();
        if (n_a < n) n = n_a;
        if (n_o < n) n = n_o;
        for (int j = 0; j < n; j++) begin
            chk("ack_onehot", $countones(ack_q[ack_base+j].vec), 1);
            chk("ack_ch",     ack_q[ack_base+j].ch, exp_ch[j]);
            chk("out_ch",     out_q[out_base+j].ch, exp_ch[j]);
            chk("dout",       out_q[out_base+j].dout, exp_y[j]);
            chk("latency",    out_q[out_base+j].cyc - ack_q[ack_base+j].cyc, 4);
            if (spacing && j > 0)
                chk("ack_spacing", ack_q[ack_base+j].cyc - ack_q[ack_base+j-1].cyc, 5);
        end
    endtask

    // Raise all channels in m at once; each drops its request when acked.
    task automatic run_round(input logic [3:0] m, input logic [4*DW-1:0] vals);
        logic [3:0] mm;
        int c;
        int guard;
        exp_ch.delete();
        exp_y.delete();
        mm = m;
        while (mm != 4'b0000) begin
            c = model_next(mm);
            mm[c] = 1'b0;
            exp_ch.push_back(c);
            exp_y.push_back(model_filter(c, int'(vals[DW*c +: DW])));
        end
        @(negedge clk);
        ack_base = ack_q.size();
        out_base = out_q.size();
        bus.din  = vals;
        bus.req  = m;
        guard = 0;
        while (bus.req != 4'b0000 && guard < 60) begin
            @(negedge clk);
            guard++;
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i] && bus.req[i]) begin
                    bus.req[i] = 1'b0;
                    bus.din[DW*i +: DW] = DW'($urandom);
                end
            end
        end
        chk("round_drained", int'(bus.req), 0);
        bus.req = '0;
        guard = 0;
        while (bus.busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("round_idle", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        check_stream(1'b0);
    endtask

    // Keep a constant request mask asserted long enough for n grants.
    task automatic hold_req(input logic [3:0] m, input logic [4*DW-1:0] vals, input int n);
        int c;
        exp_ch.delete();
        exp_y.delete();
        for (int j = 0; j < n; j++) begin
            c = model_next(m);
            exp_ch.push_back(c);
            exp_y.push_back(model_filter(c, int'(vals[DW*c +: DW])));
        end
        ack_base = ack_q.size();
        out_base = out_q.size();
        bus.din  = vals;
        bus.req  = m;
        repeat (5 * (n - 1) + 1) @(negedge clk);
        bus.req = '0;
        repeat (8) @(negedge clk);
        check_stream(1'b1);
    endtask

    vec_t            tbl[6];
    logic [4*DW-1:0] vals;
    int              guard;
    int              base;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 100,  25};
        tbl[1] = '{0, 100,  75};
        tbl[2] = '{0, 100, 100};
        tbl[3] = '{2, 255,  63};
        tbl[4] = '{2, 255, 191};
        tbl[5] = '{2, 255, 255};

        rst_n   = 1'b0;
        bus.req = '0;
        bus.din = '0;
        do_reset(4'b0000);

        // Single-channel sequences, including full-scale input.
        for (int i = 0; i < 6; i++) begin
            vals = '0;
            vals[DW*tbl[i].ch +: DW] = DW'(tbl[i].x);
            run_round(4'b0001 << tbl[i].ch, vals);
            if (out_q.size() > out_base)
                chk("tbl_dout", out_q[out_base].dout, tbl[i].y);
            chk("hold_dout",    int'(bus.dout),    tbl[i].y);
            chk("hold_dout_ch", int'(bus.dout_ch), tbl[i].ch);
        end

        // Reset while a ch1 sample sits in TAP1: it must vanish without trace.
        do_reset(4'b0000);
        vals = '0;
        vals[DW*1 +: DW] = 8'd200;
        run_round(4'b0010, vals);
        if (out_q.size() > out_base)
            chk("ch1_first_dout", out_q[out_base].dout, 50);
        @(negedge clk);
        bus.din[DW*1 +: DW] = 8'd77;
        bus.req = 4'b0010;
        guard = 0;
        while (!bus.ack[1] && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_ack_seen", int'(bus.ack[1]), 1);
        bus.req = '0;
        @(negedge clk);
        chk("abort_busy_tap1", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        base = out_q.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_vld", out_q.size() - base, 0);
        vals = '0;
        vals[DW*1 +: DW] = 8'd40;
        run_round(4'b0010, vals);
        if (out_q.size() > out_base)
            chk("post_abort_dout", out_q[out_base].dout, 10);

        // All channels requesting from reset release, then ch0/ch3 wrap fairness.
        do_reset(4'b1111);
        hold_req(4'b1111, 32'h40_30_20_10, 4);
        hold_req(4'b1001, 32'hC8_00_00_64, 6);

        // Random request masks and samples.
        do_reset(4'b0000);
        for (int r = 0; r < 30; r++) begin
            run_round(4'($urandom_range(1, 15)), $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
